// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone data-bus decoder: state encoding,
// bus widths, request payload and the default data-side memory map.
package wb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 8;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Default map: four 256 MB windows, slave i at i * 0x1000_0000
  localparam int unsigned DEF_NS      = 4;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam logic [DEF_NS*ADR_W-1:0] DEF_S_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [DEF_NS*ADR_W-1:0] DEF_S_MASK = {DEF_NS{32'hF000_0000}};

  // Request captured from the master on accept
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority address matcher: lowest-index matching window wins.
module wb_addr_match
  import wb_pkg::*;
#(
  parameter int unsigned           NS     = DEF_NS,
  parameter int unsigned           IW     = 2,
  parameter logic [NS*ADR_W-1:0]   S_BASE = (NS*ADR_W)'(DEF_S_BASE),
  parameter logic [NS*ADR_W-1:0]   S_MASK = (NS*ADR_W)'(DEF_S_MASK)
) (
  input  logic [ADR_W-1:0] adr,
  output logic [NS-1:0]    hit_c,
  output logic [IW-1:0]    idx_c,
  output logic             valid_c
);

  // Scan upward and keep only the first match
  always_comb begin
    hit_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      if (!valid_c && ((adr & S_MASK[ADR_W*i +: ADR_W]) == S_BASE[ADR_W*i +: ADR_W])) begin
        hit_c[i] = 1'b1;
        idx_c    = IW'(i);
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_data_decoder.sv
// Single-master, multi-slave Wishbone B4 pipelined address decoder for the
// core's data bus. One transaction in flight; unmapped or silent slaves get err.
module wb_data_decoder
  import wb_pkg::*;
#(
  parameter int unsigned          NS      = DEF_NS,
  parameter logic [NS*ADR_W-1:0]  S_BASE  = (NS*ADR_W)'(DEF_S_BASE),
  parameter logic [NS*ADR_W-1:0]  S_MASK  = (NS*ADR_W)'(DEF_S_MASK),
  parameter int unsigned          TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  data_wb_clk_i,
  input  logic                  data_wb_rst_i,
  input  logic                  data_wb_cyc_i,
  input  logic                  data_wb_stb_i,
  input  logic                  data_wb_we_i,
  input  logic [ADR_W-1:0]      data_wb_adr_i,
  input  logic [DAT_W-1:0]      data_wb_dat_i,
  input  logic [SEL_W-1:0]      data_wb_sel_i,
  output logic                  data_wb_stall_o,
  output logic                  data_wb_ack_o,
  output logic                  data_wb_err_o,
  output logic [DAT_W-1:0]      data_wb_dat_o,
  output logic [NS-1:0]         s_cyc_o,
  output logic [NS-1:0]         s_stb_o,
  output logic                  s_we_o,
  output logic [ADR_W-1:0]      s_adr_o,
  output logic [DAT_W-1:0]      s_dat_o,
  output logic [SEL_W-1:0]      s_sel_o,
  input  logic [NS-1:0]         s_stall_i,
  input  logic [NS-1:0]         s_ack_i,
  input  logic [NS-1:0]         s_err_i,
  input  logic [NS*DAT_W-1:0]   s_dat_i
);

  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

  logic [1:0]       state_q, state_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  wb_req_t          req_q, req_nxt;
  logic [NS-1:0]    cyc_nxt, stb_nxt;
  logic             ack_nxt, err_nxt;
  logic [DAT_W-1:0] dat_nxt;

  logic [NS-1:0]    match_hit_c;
  logic [IW-1:0]    match_idx_c;
  logic             match_valid_c;
  logic             accept_c;

  wb_addr_match #(
    .NS     (NS),
    .IW     (IW),
    .S_BASE (S_BASE),
    .S_MASK (S_MASK)
  ) u_match (
    .adr     (data_wb_adr_i),
    .hit_c   (match_hit_c),
    .idx_c   (match_idx_c),
    .valid_c (match_valid_c)
  );

  assign accept_c = data_wb_cyc_i & data_wb_stb_i & ~data_wb_stall_o;

  assign s_we_o  = req_q.we;
  assign s_adr_o = req_q.adr;
  assign s_dat_o = req_q.dat;
  assign s_sel_o = req_q.sel;

  // Next-state, slave handshake and response generation
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    req_nxt   = req_q;
    cyc_nxt   = s_cyc_o;
    stb_nxt   = s_stb_o;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = data_wb_dat_o;
    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (accept_c) begin
          req_nxt = '{we: data_wb_we_i, adr: data_wb_adr_i,
                      dat: data_wb_dat_i, sel: data_wb_sel_i};
          idx_nxt = match_idx_c;
          if (match_valid_c) begin
            state_nxt = REQ;
            cyc_nxt   = match_hit_c;
            stb_nxt   = match_hit_c;
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end
        end
      end
      REQ: begin
        if (!data_wb_cyc_i) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          stb_nxt   = '0;
        end else if (!s_stall_i[idx_q]) begin
          state_nxt = WAIT;
          stb_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (!data_wb_cyc_i) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          stb_nxt   = '0;
        end else if (s_ack_i[idx_q]) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          ack_nxt   = 1'b1;
          dat_nxt   = req_q.we ? '0 : s_dat_i[DAT_W*32'(idx_q) +: DAT_W];
        end else if (s_err_i[idx_q]) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          err_nxt   = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      req_q           <= '0;
      s_cyc_o         <= '0;
      s_stb_o         <= '0;
      data_wb_ack_o   <= 1'b0;
      data_wb_err_o   <= 1'b0;
      data_wb_dat_o   <= '0;
      data_wb_stall_o <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      idx_q           <= idx_nxt;
      cnt_q           <= cnt_nxt;
      req_q           <= req_nxt;
      s_cyc_o         <= cyc_nxt;
      s_stb_o         <= stb_nxt;
      data_wb_ack_o   <= ack_nxt;
      data_wb_err_o   <= err_nxt;
      data_wb_dat_o   <= dat_nxt;
      data_wb_stall_o <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_wb_data_decoder.sv
// Self-checking bench for wb_data_decoder: directed scenarios plus random
// transactions against a cycle-level expectation model of the decoder.
module tb_wb_data_decoder;

  localparam int unsigned NS      = 4;
  localparam int unsigned TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we;
  logic [31:0]       adr, wdat;
  logic [3:0]        sel;
  logic              stall_o, ack_o, err_o;
  logic [31:0]       dat_o;
  logic [NS-1:0]     s_cyc, s_stb;
  logic              s_we;
  logic [31:0]       s_adr, s_wdat;
  logic [3:0]        s_sel;
  logic [NS-1:0]     s_stall, s_ack, s_err;
  logic [NS*32-1:0]  s_rdat;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_dat = '0;

  always #5 clk = ~clk;

  wb_data_decoder #(.NS(NS), .TIMEOUT(TIMEOUT)) dut (
    .data_wb_clk_i   (clk),
    .data_wb_rst_i   (rst),
    .data_wb_cyc_i   (cyc),
    .data_wb_stb_i   (stb),
    .data_wb_we_i    (we),
    .data_wb_adr_i   (adr),
    .data_wb_dat_i   (wdat),
    .data_wb_sel_i   (sel),
    .data_wb_stall_o (stall_o),
    .data_wb_ack_o   (ack_o),
    .data_wb_err_o   (err_o),
    .data_wb_dat_o   (dat_o),
    .s_cyc_o         (s_cyc),
    .s_stb_o         (s_stb),
    .s_we_o          (s_we),
    .s_adr_o         (s_adr),
    .s_dat_o         (s_wdat),
    .s_sel_o         (s_sel),
    .s_stall_i       (s_stall),
    .s_ack_i         (s_ack),
    .s_err_i         (s_err),
    .s_dat_i         (s_rdat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transaction; the slave side stalls st cycles, then responds
  // d cycles into WAIT (kind 0=ack, 1=err, 2=silent). Other slaves emit noise.
  task automatic run_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                         input logic [3:0] t_sel, input int st, input int d, input int kind,
                         input bit fix_en, input logic [31:0] fix_val);
    int            t;
    bit            mapped, ack_exp;
    int            rc, ackc;
    logic [NS-1:0] oh;
    logic [31:0]   rdata;
    t       = int'(t_adr >> 28);
    mapped  = (t < int'(NS));
    oh      = '0;
    if (mapped) oh[t] = 1'b1;
    ackc    = st + 2 + d;
    ack_exp = mapped && (kind == 0) && (d <= int'(TIMEOUT));
    if (!mapped)                rc = 1;
    else if (d > int'(TIMEOUT)) rc = st + 3 + int'(TIMEOUT);
    else                        rc = ackc + 1;
    rdata = '0;

    chk("idle_stall", 64'(stall_o), 64'(0));
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
    @(posedge clk); #1;
    stb = 1'b0;
    for (int k = 1; k <= rc + 1; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk("ack_o", 64'(ack_o), 64'(ack_exp && (k == rc)));
      chk("err_o", 64'(err_o), 64'(!ack_exp && (k == rc)));
      chk("stall_o", 64'(stall_o), 64'(mapped ? (k < rc) : (k == 1)));
      chk("s_cyc", 64'(s_cyc), 64'((k < rc) ? oh : '0));
      chk("s_stb", 64'(s_stb), 64'((k <= st + 1) ? oh : '0));
      if (mapped && k == 1) begin
        chk("s_we", 64'(s_we), 64'(t_we));
        chk("s_adr", 64'(s_adr), 64'(t_adr));
        chk("s_dat", 64'(s_wdat), 64'(t_dat));
        chk("s_sel", 64'(s_sel), 64'(t_sel));
      end
      if (ack_exp && k == rc) exp_dat = t_we ? 32'h0 : rdata;
      chk("dat_o", 64'(dat_o), 64'(exp_dat));
      if (k == rc) cyc = 1'b0;
      for (int i = 0; i < int'(NS); i++) s_rdat[32*i +: 32] = $urandom;
      if (fix_en && mapped) s_rdat[32*t +: 32] = fix_val;
      s_stall = (NS'($urandom) & ~oh) | ((k <= st) ? oh : '0);
      s_ack   = (NS'($urandom) & ~oh) | ((kind == 0 && k == ackc) ? oh : '0);
      s_err   = (NS'($urandom) & ~oh) | ((kind == 1 && k == ackc) ? oh : '0);
      if (mapped && k == ackc) rdata = s_rdat[32*t +: 32];
    end
    s_stall = '0; s_ack = '0; s_err = '0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;
    s_stall = '0; s_ack = '0; s_err = '0; s_rdat = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_ack", 64'(ack_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_dat", 64'(dat_o), 64'(0));
    chk("rst_scyc", 64'(s_cyc), 64'(0));
    chk("rst_sstb", 64'(s_stb), 64'(0));
    chk("rst_sadr", 64'(s_adr), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read from slave 0
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 0, 1'b1, 32'hDEAD_BEEF);
    chk("rd0_dat", 64'(dat_o), 64'(32'hDEAD_BEEF));
    // Write to slave 2 with three stall cycles
    run_txn(1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 3, 0, 0, 1'b0, 32'h0);
    // Unmapped
    run_txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 0, 0, 1'b0, 32'h0);
    // Silent slave 1 -> timeout, then a normal follow-up
    run_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, int'(TIMEOUT) + 1, 2, 1'b0, 32'h0);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, 1, 2, 0, 1'b1, 32'hCAFE_F00D);
    // Ack on the last cycle before timeout still wins
    run_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, int'(TIMEOUT), 0, 1'b0, 32'h0);
    // Slave error
    run_txn(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'b1000, 2, 1, 1, 1'b0, 32'h0);

    // Abort in WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000_0008;
    @(posedge clk); #1;
    stb = 1'b0;
    chk("abort_stb", 64'(s_stb), 64'(4'b0010));
    @(posedge clk); #1;
    chk("abort_wait_cyc", 64'(s_cyc), 64'(4'b0010));
    cyc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_cyc", 64'(s_cyc), 64'(0));
      chk("abort_ack", 64'(ack_o), 64'(0));
      chk("abort_err", 64'(err_o), 64'(0));
      chk("abort_stall", 64'(stall_o), 64'(0));
    end

    // Asynchronous reset while in REQ
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h2000_0000; s_stall = 4'b0100;
    @(posedge clk); #1;
    stb = 1'b0;
    chk("rstreq_stb", 64'(s_stb), 64'(4'b0100));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_scyc", 64'(s_cyc), 64'(0));
    chk("arst_sstb", 64'(s_stb), 64'(0));
    chk("arst_stall", 64'(stall_o), 64'(0));
    chk("arst_sadr", 64'(s_adr), 64'(0));
    chk("arst_dat", 64'(dat_o), 64'(0));
    exp_dat = '0;
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; s_stall = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_ack", 64'(ack_o), 64'(0));
      chk("post_rst_err", 64'(err_o), 64'(0));
    end

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      int          r, kind, d;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        kind = 2; d = int'(TIMEOUT) + 1;
      end else begin
        kind = (r < 7) ? 0 : 1; d = int'($urandom_range(0, 6));
      end
      a = {4'($urandom_range(0, 7)), 28'($urandom)};
      run_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), d, kind,
              1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
